// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side inputs plus write-back and forwarding outputs.
// master = upstream/consumer side, slave = mem_wb_stage.
interface mem_wb_stage_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic              RegWrite_in;
    logic              MemtoReg_in;
    logic [REG_W-1:0]  Rd_in;
    logic [DATA_W-1:0] ALUResult_in;
    logic [DATA_W-1:0] ReadData;

    logic              RegWrite_out;
    logic [REG_W-1:0]  WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              fwd_en;
    logic [REG_W-1:0]  fwd_reg;
    logic [DATA_W-1:0] fwd_data;
    logic              wb_valid;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output in_valid, stall, flush, RegWrite_in, MemtoReg_in,
        output Rd_in, ALUResult_in, ReadData,
        input  RegWrite_out, WriteReg, WriteData,
        input  fwd_en, fwd_reg, fwd_data, wb_valid, retired_count
    );

    modport slave (
        input  in_valid, stall, flush, RegWrite_in, MemtoReg_in,
        input  Rd_in, ALUResult_in, ReadData,
        output RegWrite_out, WriteReg, WriteData,
        output fwd_en, fwd_reg, fwd_data, wb_valid, retired_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// LEGv8 MEM/WB pipeline register and write-back mux.
// Ports: clk, rst (sync, active-high), bus (mem_wb_stage_if.slave).
module mem_wb_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    localparam logic [REG_W-1:0] XZR = {REG_W{1'b1}};

    logic              valid_q, valid_d;
    logic              regwr_q, regwr_d;
    logic              m2r_q,   m2r_d;
    logic              fresh_q, fresh_d;
    logic [REG_W-1:0]  rd_q,    rd_d;
    logic [DATA_W-1:0] alu_q,   alu_d;
    logic [DATA_W-1:0] mem_q,   mem_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        valid_d = valid_q;
        regwr_d = regwr_q;
        m2r_d   = m2r_q;
        fresh_d = fresh_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            // bubble; data fields simply hold
            valid_d = 1'b0;
            regwr_d = 1'b0;
            fresh_d = 1'b0;
        end else if (bus.stall) begin
            // entry stays resident but has already written once
            fresh_d = 1'b0;
        end else begin
            valid_d = bus.in_valid;
            regwr_d = bus.RegWrite_in & bus.in_valid;
            m2r_d   = bus.MemtoReg_in;
            fresh_d = bus.in_valid;
            rd_d    = bus.Rd_in;
            alu_d   = bus.ALUResult_in;
            mem_d   = bus.ReadData;
            if (bus.in_valid)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
            m2r_q   <= 1'b0;
            fresh_q <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            regwr_q <= regwr_d;
            m2r_q   <= m2r_d;
            fresh_q <= fresh_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [DATA_W-1:0] wdata;
    logic              fwd_en;

    assign wdata  = m2r_q ? mem_q : alu_q;
    // X31 is XZR: never a forwarding source nor a write target
    assign fwd_en = valid_q & regwr_q & (rd_q != XZR);

    assign bus.WriteData     = wdata;
    assign bus.fwd_data      = wdata;
    assign bus.WriteReg      = rd_q;
    assign bus.fwd_reg       = rd_q;
    assign bus.fwd_en        = fwd_en;
    // one write strobe per entry, even across a long stall
    assign bus.RegWrite_out  = fwd_en & fresh_q;
    assign bus.wb_valid      = valid_q;
    assign bus.retired_count = cnt_q;
endmodule
